logic_op_pipe: RTL
==================

Name: logic_op_pipe

Overview:
- Parametrised, registered successor to the team's single-bit two-input gate-composition blocks.
- Applies a selectable bitwise gate function (AND/OR/NOR/NAND/XOR/XNOR/ANDN/PASS) to WIDTH-bit operands.
- Optional accumulate mode chains results across beats.
- Two-stage valid/ready pipeline that also produces zero, all-ones and popcount flags; sits between operand producers and any downstream logic-check or datapath consumer.

Parameters:
- WIDTH, 8, operand/result width in bits (≥1).
- CNT_W, $clog2(WIDTH+1), width of popcount output (derived; do not override).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- op  input  3  function select, sampled with the beat.
- acc  input  1  accumulate mode for this beat, sampled with the beat.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- Y  output  WIDTH  result.
- Y_zero  output  1  Y == 0.
- Y_ones  output  1  Y == all ones.
- Y_cnt  output  CNT_W  number of 1 bits in Y.

Behaviour:
- op encoding (X,Z = operands): 0 AND X&Z; 1 OR X|Z; 2 NOR ~(X|Z); 3 NAND ~(X&Z); 4 XOR X^Z; 5 XNOR ~(X^Z); 6 ANDN X&~Z; 7 PASS X.
- Beat accepted when in_valid && in_ready.
- Operand selection on accept:
  - acc=0: X=A, Z=B.
  - acc=1: X=acc_reg, Z=A; B is ignored.
- On every accept: r = f(op, X, Z); acc_reg <= r; stage-1 register <= r; s1_valid <= 1.
- acc_reg changes only on accept and resets to 0.
- Stage 2 loads on stage-1 advance: Y <= s1 data; Y_zero, Y_ones, Y_cnt computed from s1 data and registered together with Y.
- Flags always correspond to the Y presented in the same cycle.
- Latency: accept at edge n → out_valid with result after edge n+1 (2 register stages), no stalls.
- Handshake:
  - s2 advances out when out_valid && out_ready.
  - s2 can load when !out_valid || out_ready.
  - s1 advances to s2 when s1_valid && s2 can load.
  - in_ready = !s1_valid || (s1 advancing). Combinational from out_ready; no combinational path from in_valid to in_ready.
- Throughput: one beat/cycle with out_ready held high.
- Full pipeline (both stages valid, out_ready=0): in_ready=0. All registers hold; Y and flags stable while out_valid && !out_ready.
- Empty pipeline: out_valid=0; Y and flags hold their last values (don't-care).
- Simultaneous accept and output drain: both occur in the same cycle; no bubble, no loss, no duplication.
- Accumulate chaining across stalls: acc_reg already holds the previous accepted beat's result, so back-to-back acc beats are correct regardless of downstream stalls.
- Reset (asserted any time, including mid-transfer): immediately, independent of clk:
  - s1_valid=0, out_valid=0
  - Y=0, Y_zero=1, Y_ones=0, Y_cnt=0
  - acc_reg=0
  - in_ready=1 after reset
  - In-flight beats are discarded.
- Reset release: synchronous use of rst_n deassertion is the integrator's concern; the block accepts beats on the first edge after deassertion.
- Y_cnt range 0..WIDTH; with WIDTH=8, CNT_W=4.

Test Plan:
- Reset then op=0..7 with A=8'hC3, B=8'h0F, acc=0, out_ready=1 → Y stream C3? no: 03, CF, 30, FC, CC, 33, C0, C3, each 2 cycles after accept, one per cycle. Y_cnt = 2, 6, 2, 6, 4, 4, 2, 4.
- Accumulate: beat1 op=7 (PASS) acc=0 A=8'hF0; beat2 op=4 acc=1 A=8'hFF; beat3 op=1 acc=1 A=8'h01 → Y = F0, 0F, 0F (Y_cnt=4).
  - Beat4 op=2 acc=1 A=8'hF0 → Y=00, Y_zero=1.
- Backpressure: stream 4 beats, out_ready=0 for 5 cycles → in_ready=0 after 2 beats held; Y holds first result stable. On release, all 4 results arrive in order, none dropped or duplicated.
- Simultaneous drain and accept at full throughput with out_ready toggling 1010… → out_valid/in_ready follow the handshake rules; the sequence matches a reference model exactly.
- Reset mid-stream: assert rst_n=0 with both stages valid and acc_reg=8'hAA → out_valid=0, Y=0, Y_zero=1 immediately, without waiting for a clock edge.
  - Next beat op=1 acc=1 A=8'h01 → Y=01 (acc_reg was cleared).
- WIDTH=1 and WIDTH=13 builds: op=5 with A=B=all ones → Y_ones=1, Y_cnt=WIDTH.

Source files
------------

// File: rtl/logic_op_pipe.sv
// logic_op_pipe
//   Applies a selectable bitwise gate function to WIDTH-bit operands and
//   presents the result through a two-stage valid/ready pipeline, together
//   with zero / all-ones / popcount flags that always match the Y on the bus.
//   In accumulate mode the previous accepted result replaces operand A and
//   A replaces operand B, so gate functions can be chained across beats.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready operand beat handshake
//   A, B              operands (B ignored when acc=1)
//   op                gate select: 0 AND, 1 OR, 2 NOR, 3 NAND, 4 XOR,
//                     5 XNOR, 6 ANDN (X&~Z), 7 PASS (X)
//   acc               accumulate mode for this beat
//   out_valid/out_ready result beat handshake
//   Y                 result
//   Y_zero, Y_ones    Y == 0, Y == all ones
//   Y_cnt             number of 1 bits in Y
module logic_op_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Y_zero,
    output logic             Y_ones,
    output logic [CNT_W-1:0] Y_cnt
);

    function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    logic [WIDTH-1:0] r_acc;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_y_zero;
    logic             r_y_ones;
    logic [CNT_W-1:0] r_y_cnt;

    logic             w_accept;
    logic             w_s2_load;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_z;
    logic [WIDTH-1:0] w_r;

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_load;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_accept  = in_valid && in_ready;

    // Accumulate mode: previous accepted result is X, A moves into the Z slot.
    always_comb begin
        w_x = acc ? r_acc : A;
        w_z = acc ? A : B;
        case (op)
            3'd0:    w_r = w_x & w_z;
            3'd1:    w_r = w_x | w_z;
            3'd2:    w_r = ~(w_x | w_z);
            3'd3:    w_r = ~(w_x & w_z);
            3'd4:    w_r = w_x ^ w_z;
            3'd5:    w_r = ~(w_x ^ w_z);
            3'd6:    w_r = w_x & ~w_z;
            default: w_r = w_x;
        endcase
    end

    // Stage 1 and the accumulator. r_acc updates at accept time rather than
    // at output time, so chained beats stay correct under downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            if (w_accept) begin
                r_acc      <= w_r;
                r_s1_data  <= w_r;
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: Y and its flags are registered together so they never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_y_zero    <= 1'b1;
            r_y_ones    <= 1'b0;
            r_y_cnt     <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y      <= r_s1_data;
                r_y_zero <= (r_s1_data == '0);
                r_y_ones <= (r_s1_data == {WIDTH{1'b1}});
                r_y_cnt  <= popcnt(r_s1_data);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Y         = r_y;
    assign Y_zero    = r_y_zero;
    assign Y_ones    = r_y_ones;
    assign Y_cnt     = r_y_cnt;

endmodule
